// File: rtl/iua_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : iua_uart_tx
//  Description : 8N1 UART transmitter with a small input FIFO.
//                Bytes are pushed through a valid/ready handshake into a
//                2^LOG2_DEPTH-entry FIFO and serialized LSB first. Each bit
//                lasts DIV+1 clock cycles. Frames go out back-to-back while
//                the FIFO holds data.
//  Ports       : clk       - system clock, rising edge
//                rst_n     - asynchronous active-low reset
//                in_data   - byte to transmit
//                in_valid  - in_data is valid
//                in_ready  - FIFO can accept a byte this cycle
//                uart_tx   - registered serial line, idle high
//                idle      - FIFO empty and no frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module iua_uart_tx #(
    parameter int DIV        = 23,
    parameter int LOG2_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       uart_tx,
    output logic       idle
);

    localparam int                  C_DEPTH     = 1 << LOG2_DEPTH;
    localparam int                  C_TW        = (DIV < 1) ? 1 : $clog2(DIV + 1);
    localparam logic [C_TW-1:0]     C_DIV       = C_TW'(DIV);
    // Pointer XOR pattern that means "full": MSBs differ, low bits equal.
    localparam logic [LOG2_DEPTH:0] C_FULL_DIFF = (LOG2_DEPTH + 1)'(C_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]          r_mem [C_DEPTH];
    logic [LOG2_DEPTH:0] r_wr_ptr;
    logic [LOG2_DEPTH:0] r_rd_ptr;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = ((r_wr_ptr ^ r_rd_ptr) == C_FULL_DIFF);
    // in_ready depends only on registered pointers, so a pop in the same
    // cycle never lets a full FIFO take a byte.
    assign in_ready = ~w_full;
    assign w_push   = in_valid & ~w_full;

    // Storage carries no reset; the pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[LOG2_DEPTH-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic [C_TW-1:0] r_timer;
    logic [C_TW-1:0] w_timer_nxt;
    logic [2:0]      r_bit_idx;
    logic [2:0]      w_bit_idx_nxt;
    logic [7:0]      r_shift;
    logic            w_tx_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            uart_tx   <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            uart_tx   <= w_tx_nxt;
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr[LOG2_DEPTH-1:0]];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_bit_idx_nxt = r_bit_idx;
        w_pop         = 1'b0;
        // The line follows the current state, so it trails the state
        // register by one cycle; every level still lasts DIV+1 cycles.
        w_tx_nxt      = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_state_nxt = S_START;
                    w_timer_nxt = C_DIV;
                    w_pop       = 1'b1;
                end
            end
            S_START: begin
                w_tx_nxt = 1'b0;
                if (r_timer == '0) begin
                    w_state_nxt   = S_DATA;
                    w_timer_nxt   = C_DIV;
                    w_bit_idx_nxt = 3'd0;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            S_DATA: begin
                w_tx_nxt = r_shift[r_bit_idx];
                if (r_timer == '0) begin
                    w_timer_nxt = C_DIV;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt   = S_STOP;
                        w_bit_idx_nxt = 3'd0;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (r_timer == '0) begin
                    // Chain straight into the next frame when data waits.
                    if (!w_empty) begin
                        w_state_nxt = S_START;
                        w_timer_nxt = C_DIV;
                        w_pop       = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign idle = (r_state == S_IDLE) & w_empty;

endmodule
`default_nettype wire

// File: tb/tb_iua_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iua_uart_tx
//  Description : Directed self-checking bench for iua_uart_tx. One instance
//                uses DIV=23, a second uses DIV=0 for single-cycle bits.
//                A reference receiver decodes the DIV=23 line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iua_uart_tx;

    localparam int P = 24;   // cycles per bit of the DIV=23 instance

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       uart_tx;
    logic       idle;
    logic [7:0] in_data0;
    logic       in_valid0;
    logic       in_ready0;
    logic       uart_tx0;
    logic       idle0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rst_count = 0;

    logic [7:0] rxq[$];
    int         rx_start[$];
    int         rx_frame_err = 0;
    logic [7:0] acc_q[$];

    iua_uart_tx #(.DIV(23), .LOG2_DEPTH(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .uart_tx (uart_tx),
        .idle    (idle)
    );

    iua_uart_tx #(.DIV(0), .LOG2_DEPTH(2)) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data0),
        .in_valid(in_valid0),
        .in_ready(in_ready0),
        .uart_tx (uart_tx0),
        .idle    (idle0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) rst_count = rst_count + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference 8N1 receiver: samples mid-bit, drops frames cut by reset.
    initial begin : rx_model
        int         t0;
        int         rc;
        logic [7:0] b;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && uart_tx === 1'b0) begin
                t0 = cyc;
                rc = rst_count;
                repeat (P / 2) begin @(posedge clk); #2; end
                for (int i = 0; i < 8; i++) begin
                    repeat (P) begin @(posedge clk); #2; end
                    b[i] = uart_tx;
                end
                repeat (P) begin @(posedge clk); #2; end
                if (rc == rst_count) begin
                    if (uart_tx !== 1'b1) rx_frame_err++;
                    rxq.push_back(b);
                    rx_start.push_back(t0);
                end
            end
        end
    end

    initial begin : stim
        logic [9:0]  exp_frame;
        logic [19:0] exp_line0;
        logic        saw_full;
        logic        acc;
        int          w;

        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_data0  = 8'h00;
        in_valid0 = 1'b0;
        rst_n     = 1'b1;

        // ---------------- reset ----------------
        #1 rst_n = 1'b0;
        #1;
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_idle", {31'd0, idle}, 32'd1);
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("post_rst_tx", {31'd0, uart_tx}, 32'd1);
            check("post_rst_ready", {31'd0, in_ready}, 32'd1);
            check("post_rst_idle", {31'd0, idle}, 32'd1);
        end

        // ---------------- single byte 0x55 ----------------
        rxq.delete(); rx_start.delete();
        exp_frame = {1'b1, 8'h55, 1'b0};      // bit0 = start, bit9 = stop
        in_data  = 8'h55;
        in_valid = 1'b1;
        tick();                               // edge k: accepted
        in_valid = 1'b0;
        check("single_idle_busy", {31'd0, idle}, 32'd0);
        tick();                               // edge k+1
        check("single_k1_high", {31'd0, uart_tx}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("single_bit_first", {31'd0, uart_tx}, {31'd0, exp_frame[i]});
            repeat (P - 1) tick();
            check("single_bit_last", {31'd0, uart_tx}, {31'd0, exp_frame[i]});
        end
        tick();                               // edge k+242
        check("single_idle_end", {31'd0, idle}, 32'd1);
        check("single_tx_end", {31'd0, uart_tx}, 32'd1);
        check("single_rx_count", rxq.size(), 32'd1);
        if (rxq.size() > 0) check("single_rx_byte", {24'd0, rxq[0]}, 32'h55);

        // ---------------- burst 0x01..0x06 ----------------
        rxq.delete(); rx_start.delete();
        saw_full = 1'b0;
        for (int b = 1; b <= 6; b++) begin
            in_data  = 8'(b);
            in_valid = 1'b1;
            acc = 1'b0;
            w = 0;
            while (!acc && w < 2000) begin
                if (!in_ready) saw_full = 1'b1;
                acc = in_ready;
                tick();
                w++;
            end
            check("burst_accept", {31'd0, acc}, 32'd1);
        end
        in_valid = 1'b0;
        check("burst_saw_full", {31'd0, saw_full}, 32'd1);
        w = 0;
        while (rxq.size() < 6 && w < 3000) begin tick(); w++; end
        check("burst_rx_count", rxq.size(), 32'd6);
        if (rxq.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("burst_order", {24'd0, rxq[i]}, i + 1);
            end
            for (int i = 1; i < 6; i++) begin
                check("burst_gap", rx_start[i] - rx_start[i-1], 32'd240);
            end
            check("burst_span", rx_start[5] - rx_start[0] + 240, 32'd1440);
        end
        w = 0;
        while (!idle && w < 500) begin tick(); w++; end
        check("burst_idle", {31'd0, idle}, 32'd1);

        // ---------------- mid-frame reset ----------------
        rxq.delete(); rx_start.delete();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();                               // edge k
        in_data  = 8'h11;
        tick();
        in_data  = 8'h22;
        tick();                               // edge k+2
        in_valid = 1'b0;
        repeat (103) tick();                  // edge k+105: data bit 3
        check("midrst_bit3_low", {31'd0, uart_tx}, 32'd0);
        check("midrst_busy", {31'd0, idle}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_tx_async", {31'd0, uart_tx}, 32'd1);
        check("midrst_idle", {31'd0, idle}, 32'd1);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 600; i++) begin
            tick();
            check("midrst_line_high", {31'd0, uart_tx}, 32'd1);
        end
        check("midrst_idle_after", {31'd0, idle}, 32'd1);
        check("midrst_rx_none", rxq.size(), 32'd0);

        // ---------------- DIV=0: 0x00 then 0xFF ----------------
        // Line order, first sample in bit 0.
        exp_line0 = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
        in_valid0 = 1'b1;
        in_data0  = 8'h00;
        tick();                               // edge k
        in_data0  = 8'hFF;
        tick();                               // edge k+1
        in_valid0 = 1'b0;
        for (int j = 0; j < 20; j++) begin
            tick();                           // edge k+2+j
            check("div0_line", {31'd0, uart_tx0}, {31'd0, exp_line0[j]});
        end
        tick();                               // edge k+22
        check("div0_idle", {31'd0, idle0}, 32'd1);
        check("div0_tx_idle", {31'd0, uart_tx0}, 32'd1);

        // ---------------- backpressure ----------------
        rxq.delete(); rx_start.delete(); acc_q.delete();
        saw_full = 1'b0;
        in_data  = 8'($urandom);
        for (int i = 0; i < 1200; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            acc = in_valid & in_ready;
            if (in_valid && !in_ready) saw_full = 1'b1;
            if (acc) acc_q.push_back(in_data);
            tick();
            if (acc) in_data = 8'($urandom);
        end
        in_valid = 1'b0;
        check("bp_saw_full", {31'd0, saw_full}, 32'd1);
        w = 0;
        while ((rxq.size() < acc_q.size() || !idle) && w < 5000) begin tick(); w++; end
        check("bp_rx_count", rxq.size(), acc_q.size());
        if (rxq.size() == acc_q.size()) begin
            for (int i = 0; i < acc_q.size(); i++) begin
                check("bp_rx_byte", {24'd0, rxq[i]}, {24'd0, acc_q[i]});
            end
        end
        repeat (40) tick();
        check("rx_frame_errors", rx_frame_err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
